// File: rtl/key_debounce_scan.sv
// key_debounce_scan: NUM_KEYS active-low push-buttons, each through a 2-FF
// synchronizer and a 4-state debounce FSM. The FSM emits a registered level
// and one-cycle press/release pulses.
// Optional build macro LONG_PRESS_EN adds a per-key hold counter that drives
// key_long. Without the macro key_long is tied to 0. The port list is the same
// in both builds.

module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
`ifdef LONG_PRESS_EN
  parameter int LONG_CYCLES     = 50_000_000,
`endif
  parameter int CNT_W           = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);
  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_DB_PRESS   = 2'd1;
  localparam logic [1:0] S_PRESSED    = 2'd2;
  localparam logic [1:0] S_DB_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, ks_q;
  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, press_q, rel_q;
  logic             press_d, rel_d;

  // Two-stage synchronizer; idles at 1 (released) so reset never looks like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      ks_q    <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      ks_q    <= sync1_q;
    end
  end

  // Debounce FSM next state; the counter restarts on every state change so it never wraps
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (!ks_q) begin
          st_d  = S_DB_PRESS;
          cnt_d = '0;
        end
      end
      S_DB_PRESS: begin
        if (ks_q) begin
          st_d  = S_IDLE;
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          st_d    = S_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESSED: begin
        if (ks_q) begin
          st_d  = S_DB_RELEASE;
          cnt_d = '0;
        end
      end
      S_DB_RELEASE: begin
        if (!ks_q) begin
          st_d  = S_PRESSED;
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          st_d  = S_IDLE;
          cnt_d = '0;
          rel_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        st_d  = S_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // FSM state, counter and registered level/event outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= (st_d == S_PRESSED) || (st_d == S_DB_RELEASE);
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Hold counter: cleared on a confirmed press. It advances while the key is
  // held, including during a release debounce. It freezes on a rejected
  // release bounce. It parks at LONG_CYCLES so the long event fires only once.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (st_q == S_DB_PRESS && st_d == S_PRESSED) begin
      hold_d = '0;
    end else if ((st_q == S_PRESSED || (st_q == S_DB_RELEASE && st_d == S_DB_RELEASE))
                 && hold_q != LONG_SAT) begin
      hold_d = hold_q + CNT_ONE;
      long_d = (hold_q == LONG_LAST);
    end
  end

  // Hold counter and long-press pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif
endmodule

module key_debounce_scan #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int CNT_W           = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);
  // Reject parameter sets that the counters cannot handle
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
    $error("key_debounce_scan: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
  end

  // Each key is a fully independent channel
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef LONG_PRESS_EN
      .LONG_CYCLES     (LONG_CYCLES),
`endif
      .CNT_W           (CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n_i   (key_n[k]),
      .state_o   (key_state[k]),
      .press_o   (key_press[k]),
      .release_o (key_release[k]),
      .long_o    (key_long[k])
    );
  end
endmodule

// File: tb/tb_key_debounce_scan.sv
// Bench for key_debounce_scan. It runs directed scenarios and then random
// bouncing keys. Each cycle the outputs are checked against a run-length
// model. In that model a key flips its debounced level after DB+1
// consecutive synchronized samples that disagree with it.
module tb_key_debounce_scan;
  localparam int NK = 4;
  localparam int DB = 16;
  localparam int LG = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_state, key_press, key_release, key_long;

  key_debounce_scan #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit s1 [NK];
  bit s2 [NK];
  bit deb[NK];
  int run[NK];
  int hold[NK];
  logic [NK-1:0] e_state, e_press, e_rel, e_long;

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      s1[k] = 1'b1; s2[k] = 1'b1; deb[k] = 1'b0; run[k] = 0; hold[k] = 0;
    end
    e_state = '0; e_press = '0; e_rel = '0; e_long = '0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      bit p, was, bounce;
      p = ~s2[k];
      was = deb[k];
      bounce = 1'b0;
      s2[k] = s1[k];
      s1[k] = key_n[k];
      e_press[k] = 1'b0; e_rel[k] = 1'b0; e_long[k] = 1'b0;
      if (p != deb[k]) begin
        run[k]++;
        if (run[k] == DB + 1) begin
          deb[k] = p;
          run[k] = 0;
          if (p) begin e_press[k] = 1'b1; hold[k] = 0; end
          else e_rel[k] = 1'b1;
        end
      end else begin
        bounce = (run[k] > 0);
        run[k] = 0;
      end
      if (was && deb[k] && !bounce && hold[k] < LG) begin
        if (hold[k] == LG - 1) e_long[k] = 1'b1;
        hold[k]++;
      end
`ifndef LONG_PRESS_EN
      e_long[k] = 1'b0;
`endif
      e_state[k] = deb[k];
    end
  endtask

  // One clock: advance the model on the edge, then compare just after it
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    chk("state",   key_state,   e_state);
    chk("press",   key_press,   e_press);
    chk("release", key_release, e_rel);
    chk("long",    key_long,    e_long);
  endtask

  int first, npress, nrel, nlong, press_at, long_at, sawstate;
  logic [NK-1:0] pvec;
  int remain[NK];

  initial begin
    model_reset();
    // 1. reset with keys released, then keys toggling under reset
    #1;
    chk("rst_state", key_state, 4'b0);
    chk("rst_press", key_press, 4'b0);
    for (int i = 0; i < 6; i++) begin
      key_n = 4'($urandom);
      tick();
      chk("rst_toggle_out", {key_state, key_press, key_release, key_long}, 16'h0);
    end
    key_n = '1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // 2. key 0 press latency and release latency
    key_n[0] = 1'b0;
    first = 0; npress = 0; sawstate = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (key_press[0]) begin npress++; if (first == 0) begin first = n; sawstate = key_state[0]; end end
    end
    chk("t2_press_lat", first, 19);
    chk("t2_press_cnt", npress, 1);
    chk("t2_state_with_press", sawstate, 1);
    key_n[0] = 1'b1;
    first = 0; nrel = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (key_release[0]) begin nrel++; if (first == 0) first = n; end
    end
    chk("t2_rel_lat", first, 19);
    chk("t2_rel_cnt", nrel, 1);

    // 3. short glitch rejected; bouncy release yields one release
    key_n[1] = 1'b0;
    npress = 0; sawstate = 0;
    for (int n = 0; n < 10; n++) begin tick(); npress += key_press[1]; sawstate |= key_state[1]; end
    key_n[1] = 1'b1;
    for (int n = 0; n < 30; n++) begin tick(); npress += key_press[1]; sawstate |= key_state[1]; end
    chk("t3_glitch_press", npress, 0);
    chk("t3_glitch_state", sawstate, 0);
    key_n[1] = 1'b0;
    for (int n = 0; n < 25; n++) tick();
    chk("t3_held_state", key_state[1], 1);
    nrel = 0;
    for (int b = 0; b < 4; b++) begin
      key_n[1] = b[0] ? 1'b0 : 1'b1;
      for (int n = 0; n < 5; n++) begin tick(); nrel += key_release[1]; end
    end
    chk("t3_bounce_state", key_state[1], 1);
    key_n[1] = 1'b1;
    for (int n = 0; n < 40; n++) begin tick(); nrel += key_release[1]; end
    chk("t3_rel_cnt", nrel, 1);
    chk("t3_final_state", key_state[1], 0);

    // 4. simultaneous press and release on keys 0 and 3
    key_n = 4'b0110;
    pvec = '0; npress = 0;
    for (int n = 0; n < 25; n++) begin tick(); if (key_press != 0) begin npress++; pvec = key_press; end end
    chk("t4_press_vec", pvec, 4'b1001);
    chk("t4_press_cycles", npress, 1);
    key_n = 4'b1111;
    pvec = '0; nrel = 0;
    for (int n = 0; n < 25; n++) begin tick(); if (key_release != 0) begin nrel++; pvec = key_release; end end
    chk("t4_rel_vec", pvec, 4'b1001);
    chk("t4_rel_cycles", nrel, 1);

    // 5. long hold on key 2
    key_n[2] = 1'b0;
    press_at = -1; long_at = -1; nlong = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (key_press[2]) press_at = n;
      if (key_long[2]) begin nlong++; long_at = n; end
      if (key_long != 0 && key_long != 4'b0100) chk("t5_long_other", key_long, 4'b0100);
    end
    key_n[2] = 1'b1;
    for (int n = 0; n < 25; n++) begin tick(); nlong += key_long[2]; end
`ifdef LONG_PRESS_EN
    chk("t5_long_delay", long_at - press_at, 64);
    chk("t5_long_cnt", nlong, 1);
`else
    chk("t5_long_cnt", nlong, 0);
`endif

    // 6. async reset mid-debounce with key 3 already pressed
    key_n[3] = 1'b0;
    for (int n = 0; n < 25; n++) tick();
    chk("t6_pre_state", key_state, 4'b1000);
    key_n[0] = 1'b0;
    for (int n = 0; n < 11; n++) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_async_state", key_state, 4'b0);
    chk("t6_async_evt", {key_press, key_release, key_long}, 12'h0);
    tick(); tick();
    rst_n = 1'b1;
    first = 0; pvec = '0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (key_press != 0 && first == 0) begin first = n; pvec = key_press; end
    end
    chk("t6_press_lat", first, 19);
    chk("t6_press_vec", pvec, 4'b1001);

    // 7. random bouncing keys, with one reset pulse partway through
    for (int k = 0; k < NK; k++) remain[k] = 1 + $urandom_range(0, 30);
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NK; k++) begin
        remain[k]--;
        if (remain[k] <= 0) begin
          key_n[k] = ~key_n[k];
          remain[k] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 20) : $urandom_range(20, 120);
        end
      end
      if (n == 1500) rst_n = 1'b0;
      if (n == 1503) rst_n = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
